nubus_slave_resp: RTL and testbench

NUBUS_SLAVE_RESP -- requirements
Module: nubus_slave_resp

---
 rtl/nubus_slave_resp.sv | 125 ++++++++++++
 tb/tb_nubus_slave_resp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nubus_slave_resp.sv
// nubus_slave_resp: NuBus slave that turns NuBus read/write cycles into single memory requests
//   mem_clk, mem_reset      : clock (rising edge = NuBus sample edge), synchronous active-high reset
//   nub_idn                 : active-low slot ID
//   nub_startn/ackn/tm0n/tm1n, nub_adn : active-low NuBus inputs
//   nub_adn_o/nub_ad_oe     : AD drive value and enable (read data during ACK)
//   nub_tmn_o/nub_ackn_o/nub_ctl_oe : status, ACK and their shared enable
//   mem_valid/ready, mem_addr/wstrb/wdata/rdata : memory request port
//   mem_myslot              : latched slot match of the current transaction
module nubus_slave_resp #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        mem_clk,
    input  logic        mem_reset,
    input  logic [3:0]  nub_idn,
    input  logic        nub_startn,
    input  logic        nub_ackn,
    input  logic        nub_tm0n,
    input  logic        nub_tm1n,
    input  logic [31:0] nub_adn,
    output logic [31:0] nub_adn_o,
    output logic        nub_ad_oe,
    output logic [1:0]  nub_tmn_o,
    output logic        nub_ackn_o,
    output logic        nub_ctl_oe,
    output logic        mem_valid,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_myslot
);
    typedef enum logic [1:0] {IDLE, WDATA, MEM, ACK} state_t;
    localparam logic [1:0] ST_OK  = 2'b11;
    localparam logic [1:0] ST_ERR = 2'b10;
    localparam logic [1:0] ST_TO  = 2'b01;

    state_t      r_state, w_next;
    logic [31:0] w_a;
    logic        w_start, w_match, w_block, w_timeout, w_ack;
    logic [3:0]  w_mask;
    logic        r_write, r_myslot;
    logic [1:0]  r_status;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_wstrb;

    assign w_a       = ~nub_adn;
    assign w_start   = r_state == IDLE && !nub_startn && nub_ackn;
    assign w_match   = w_a[31:24] == {4'hF, ~nub_idn};
    assign w_block   = nub_tm0n && w_a[1:0] == 2'b01;
    assign w_mask    = !nub_tm0n ? 4'b0001 << w_a[1:0] :
                       w_a[1:0] == 2'b00 ? 4'hF :
                       w_a[1:0] == 2'b10 ? 4'h3 :
                       w_a[1:0] == 2'b11 ? 4'hC : 4'h0;
    // r_cnt holds the number of MEM edges already spent without mem_ready
    assign w_timeout = r_cnt == 8'(TIMEOUT_CYCLES - 1);
    assign w_ack     = r_state == ACK;

    always_ff @(posedge mem_clk) begin
        if (mem_reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start && w_match) w_next = w_block ? ACK : !nub_tm1n ? WDATA : MEM;
            WDATA:   w_next = MEM;
            MEM:     if (mem_ready || w_timeout) w_next = ACK;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            r_write  <= 1'b0;
            r_myslot <= 1'b0;
            r_status <= ST_OK;
            r_cnt    <= 8'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_wstrb  <= 4'h0;
        end else begin
            if (w_start)
                r_myslot <= w_match;
            else if (w_ack)
                r_myslot <= 1'b0;
            if (w_start && w_match) begin
                r_write  <= !nub_tm1n;
                r_addr   <= {w_a[31:2], 2'b00};
                r_wstrb  <= !nub_tm1n ? w_mask : 4'h0;
                // cleared so reads that end in error/timeout return all-ones on AD
                r_rdata  <= 32'd0;
                r_status <= w_block ? ST_ERR : ST_OK;
            end
            if (r_state == WDATA)
                r_wdata <= w_a;
            r_cnt <= r_state == MEM ? r_cnt + 8'd1 : 8'd0;
            if (r_state == MEM) begin
                if (mem_ready && !r_write)
                    r_rdata <= mem_rdata;
                else if (!mem_ready && w_timeout)
                    r_status <= ST_TO;
            end
        end
    end

    always_comb begin
        mem_valid  = r_state == MEM;
        nub_ctl_oe = w_ack;
        nub_ackn_o = !w_ack;
        nub_tmn_o  = w_ack ? r_status : ST_OK;
        nub_ad_oe  = w_ack && !r_write;
        nub_adn_o  = w_ack && !r_write ? ~r_rdata : '1;
    end

    assign mem_addr   = r_addr;
    assign mem_wstrb  = r_wstrb;
    assign mem_wdata  = r_wdata;
    assign mem_myslot = r_myslot;
endmodule

// File: tb/tb_nubus_slave_resp.sv
// tb_nubus_slave_resp: randomized transaction-level check of nubus_slave_resp against a cycle timeline model
module tb_nubus_slave_resp;
    localparam int TO = 4;

    logic        mem_clk = 1'b0;
    logic        mem_reset;
    logic [3:0]  nub_idn;
    logic        nub_startn, nub_ackn, nub_tm0n, nub_tm1n;
    logic [31:0] nub_adn;
    logic [31:0] nub_adn_o;
    logic        nub_ad_oe, nub_ackn_o, nub_ctl_oe;
    logic [1:0]  nub_tmn_o;
    logic        mem_valid, mem_ready, mem_myslot;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    nubus_slave_resp #(.TIMEOUT_CYCLES(TO)) dut (
        .mem_clk(mem_clk), .mem_reset(mem_reset), .nub_idn(nub_idn),
        .nub_startn(nub_startn), .nub_ackn(nub_ackn), .nub_tm0n(nub_tm0n), .nub_tm1n(nub_tm1n),
        .nub_adn(nub_adn), .nub_adn_o(nub_adn_o), .nub_ad_oe(nub_ad_oe), .nub_tmn_o(nub_tmn_o),
        .nub_ackn_o(nub_ackn_o), .nub_ctl_oe(nub_ctl_oe), .mem_valid(mem_valid), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_myslot(mem_myslot)
    );

    always #5 mem_clk = ~mem_clk;

    int n_chk, n_fail, cyc, t_start, t_ack, vcnt, acnt, vb, ab;
    logic        en = 1'b0;
    logic        e_valid, e_ack, e_ad_oe, e_myslot, e_chk_wd;
    logic [1:0]  e_tmn;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr, e_wdata, e_adn;
    logic [31:0] cap_addr, cap_wdata, cap_adn;
    logic [3:0]  cap_wstrb;
    logic [1:0]  cap_tmn;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(posedge mem_clk) begin
        cyc <= cyc + 1;
        if (!nub_ackn_o) begin
            t_ack <= cyc + 1;
            acnt  <= acnt + 1;
        end
    end

    always @(negedge mem_clk) begin
        if (mem_valid) begin
            vcnt      <= vcnt + 1;
            cap_addr  <= mem_addr;
            cap_wstrb <= mem_wstrb;
            cap_wdata <= mem_wdata;
        end
        if (!nub_ackn_o) begin
            cap_tmn <= nub_tmn_o;
            cap_adn <= nub_adn_o;
        end
        if (en) begin
            chk("mem_valid", 32'(mem_valid), 32'(e_valid));
            chk("ctl_oe", 32'(nub_ctl_oe), 32'(e_ack));
            chk("ackn_o", 32'(nub_ackn_o), 32'(!e_ack));
            chk("tmn_o", 32'(nub_tmn_o), 32'(e_tmn));
            chk("ad_oe", 32'(nub_ad_oe), 32'(e_ad_oe));
            chk("adn_o", nub_adn_o, e_adn);
            chk("myslot", 32'(mem_myslot), 32'(e_myslot));
            if (e_valid) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
            end
            if (e_chk_wd)
                chk("mem_wdata", mem_wdata, e_wdata);
        end
    end

    task automatic step();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic exp_idle();
        e_valid = 0; e_ack = 0; e_ad_oe = 0; e_tmn = 2'b11; e_myslot = 0; e_chk_wd = 0; e_adn = '1;
    endtask

    task automatic exp_mem(input logic wr);
        e_valid = 1; e_ack = 0; e_ad_oe = 0; e_tmn = 2'b11; e_myslot = 1; e_chk_wd = wr; e_adn = '1;
    endtask

    task automatic noise();
        nub_startn = 1'($urandom_range(0, 1));
        nub_ackn   = 1'($urandom_range(0, 1));
        nub_tm0n   = 1'($urandom_range(0, 1));
        nub_tm1n   = 1'($urandom_range(0, 1));
        nub_idn    = 4'($urandom);
        nub_adn    = $urandom;
    endtask

    task automatic drive_start(input logic [3:0] idn, input logic wr, input logic tm0n, input logic [31:0] addr);
        nub_idn = idn; nub_startn = 0; nub_ackn = 1; nub_tm1n = !wr; nub_tm0n = tm0n; nub_adn = ~addr;
        mem_ready = 0; mem_rdata = $urandom;
    endtask

    // one full transaction; dly = MEM cycles before mem_ready is presented
    task automatic txn(input logic [3:0] idn, input logic wr, input logic tm0n, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] rdata, input int dly);
        logic [3:0] mask;
        logic [1:0] st;
        logic       blk;
        blk = tm0n && addr[1:0] == 2'b01;
        if (!tm0n) mask = 4'b0001 << addr[1:0];
        else case (addr[1:0])
            2'd0:    mask = 4'b1111;
            2'd2:    mask = 4'b0011;
            2'd3:    mask = 4'b1100;
            default: mask = 4'b0000;
        endcase
        drive_start(idn, wr, tm0n, addr);
        step();
        t_start = cyc;
        if (addr[31:24] != {4'hF, ~idn}) begin
            exp_idle();
            nub_startn = 1;
            nub_adn = $urandom;
            return;
        end
        e_addr = {addr[31:2], 2'b00};
        e_wstrb = wr ? mask : 4'h0;
        e_wdata = data;
        st = 2'b10;
        if (!blk) begin
            if (wr) begin
                exp_idle();
                e_myslot = 1;
                noise();
                nub_adn = ~data;
                step();
            end
            for (int i = 0; i < TO; i++) begin
                exp_mem(wr);
                noise();
                mem_ready = i == dly;
                mem_rdata = i == dly ? rdata : $urandom;
                step();
                if (i == dly) break;
            end
            mem_ready = 0;
            st = dly < TO ? 2'b11 : 2'b01;
        end
        e_valid = 0; e_chk_wd = 0; e_ack = 1; e_tmn = st; e_ad_oe = !wr; e_myslot = 1;
        e_adn = (!wr && st == 2'b11) ? ~rdata : '1;
        noise();
        step();
        exp_idle();
        nub_startn = 1;
    endtask

    initial begin
        logic [3:0]  idn;
        logic [31:0] addr;
        mem_reset = 1; nub_idn = 4'hF; nub_startn = 1; nub_ackn = 1; nub_tm0n = 1; nub_tm1n = 1;
        nub_adn = '1; mem_rdata = 0; mem_ready = 0;
        exp_idle();
        step();
        step();
        en = 1;
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_myslot", 32'(mem_myslot), 32'd0);
        chk("rst_oe", 32'({nub_ad_oe, nub_ctl_oe}), 32'd0);
        chk("rst_ackn", 32'(nub_ackn_o), 32'd1);
        chk("rst_tmn", 32'(nub_tmn_o), 32'd3);
        chk("rst_adn", nub_adn_o, 32'hFFFFFFFF);
        mem_reset = 0;
        step();

        txn(4'hF, 1, 1, 32'hF0000000, 32'h87654321, 0, 0);
        chk("wr_addr", cap_addr, 32'hF0000000);
        chk("wr_wstrb", 32'(cap_wstrb), 32'hF);
        chk("wr_wdata", cap_wdata, 32'h87654321);
        chk("wr_lat", 32'(t_ack - t_start), 32'd3);
        chk("wr_status", 32'(cap_tmn), 32'd3);

        vb = vcnt;
        txn(4'hF, 0, 0, 32'hF0000016, 0, 32'h00650000, 0);
        chk("rd_addr", cap_addr, 32'hF0000014);
        chk("rd_wstrb", 32'(cap_wstrb), 32'd0);
        chk("rd_valid_cycles", 32'(vcnt - vb), 32'd1);
        chk("rd_adn", cap_adn, 32'hFF9AFFFF);
        chk("rd_status", 32'(cap_tmn), 32'd3);
        chk("rd_lat", 32'(t_ack - t_start), 32'd2);

        vb = vcnt; ab = acnt;
        txn(4'hF, 0, 1, 32'hE0000000, 0, 0, 0);
        step();
        txn(4'hF, 1, 1, 32'hF1000000, 0, 0, 0);
        step();
        chk("nomatch_valid", 32'(vcnt - vb), 32'd0);
        chk("nomatch_ack", 32'(acnt - ab), 32'd0);

        vb = vcnt;
        txn(4'hF, 0, 1, 32'hF0000040, 0, 32'h12345678, 100);
        chk("to_valid_cycles", 32'(vcnt - vb), 32'd4);
        chk("to_status", 32'(cap_tmn), 32'd1);

        vb = vcnt;
        txn(4'hF, 1, 1, 32'hF0000081, 32'hDEADBEEF, 0, 0);
        chk("blk_valid", 32'(vcnt - vb), 32'd0);
        chk("blk_status", 32'(cap_tmn), 32'd2);

        ab = acnt;
        drive_start(4'hF, 0, 1, 32'hF0000100);
        step();
        e_addr = 32'hF0000100; e_wstrb = 0;
        exp_mem(0);
        nub_startn = 1;
        step();
        exp_mem(0);
        mem_reset = 1;
        step();
        exp_idle();
        mem_reset = 0;
        step();
        step();
        chk("rst_mid_ack", 32'(acnt - ab), 32'd0);
        txn(4'hF, 0, 1, 32'hF0000200, 0, 32'hCAFEF00D, 1);
        chk("post_rst_status", 32'(cap_tmn), 32'd3);
        chk("post_rst_adn", cap_adn, 32'h35010FF2);

        for (int k = 0; k < 400; k++) begin
            idn = 4'($urandom);
            addr = $urandom_range(0, 9) < 8 ? {4'hF, ~idn, 24'($urandom)} : $urandom;
            txn(idn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom, $urandom,
                int'($urandom_range(0, 6)));
        end
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
